// File: rtl/id_ex_if.sv
// id_ex_if - handshake and data bundle between IF/ID, the decode/issue stage
// and the EX stage.
//   master : upstream/downstream side (drives instruction, register data,
//            flush and ex_ready; observes in_ready and the ID/EX register)
//   slave  : the id_ex_stage itself
interface id_ex_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [3:0]  ex_ALUcontrol;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_branch;
  logic        ex_illegal;
  logic [31:0] issue_count;

  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, ex_ready,
    input  in_ready, ex_valid, ex_A, ex_B, ex_ALUcontrol, ex_imm, ex_pc,
           ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
           ex_illegal, issue_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, ex_ready,
    output in_ready, ex_valid, ex_A, ex_B, ex_ALUcontrol, ex_imm, ex_pc,
           ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
           ex_illegal, issue_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage - RV32 decode/issue stage feeding the ALU.
// Decodes the IF/ID instruction into ALU operands, a 4-bit ALU op and
// memory/writeback control, and registers them into the ID/EX register with
// a valid/ready handshake, stall and flush. Counts issued instructions.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - id_ex_if.slave: in_valid/in_ready/in_instr/in_pc/rs1_data/
//          rs2_data/flush/ex_ready in, ex_* register outputs and issue_count
module id_ex_stage (
  input logic    clk,
  input logic    rst,
  id_ex_if.slave bus
);
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];
  assign rd     = bus.in_instr[11:7];
  assign shamt  = bus.in_instr[24:20];
  assign imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_s  = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
  assign imm_b  = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                   bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
  assign imm_u  = {bus.in_instr[31:12], 12'b0};

  logic [31:0] d_a, d_b, d_imm;
  logic [3:0]  d_alu;
  logic [4:0]  d_rd;
  logic        d_writer, d_regwrite, d_memread, d_memwrite, d_branch, d_illegal;

  always_comb begin
    d_a        = '0;
    d_b        = '0;
    d_imm      = '0;
    d_alu      = ALU_AND;
    d_writer   = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_branch   = 1'b0;
    d_illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        d_a      = bus.rs1_data;
        d_b      = bus.rs2_data;
        d_writer = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: d_alu = ALU_ADD;
          {F7_ALT,  3'b000}: d_alu = ALU_SUB;
          {F7_BASE, 3'b001}: begin d_alu = ALU_SLL; d_b = {27'b0, bus.rs2_data[4:0]}; end
          {F7_BASE, 3'b100}: d_alu = ALU_XOR;
          {F7_BASE, 3'b101}: begin d_alu = ALU_SRL; d_b = {27'b0, bus.rs2_data[4:0]}; end
          {F7_ALT,  3'b101}: begin d_alu = ALU_SRA; d_b = {27'b0, bus.rs2_data[4:0]}; end
          {F7_BASE, 3'b110}: d_alu = ALU_OR;
          {F7_BASE, 3'b111}: d_alu = ALU_AND;
          default:           d_illegal = 1'b1;
        endcase
      end
      OP_I: begin
        d_a      = bus.rs1_data;
        d_b      = imm_i;
        d_imm    = imm_i;
        d_writer = 1'b1;
        case (funct3)
          3'b000: d_alu = ALU_ADD;
          3'b100: d_alu = ALU_XOR;
          3'b110: d_alu = ALU_OR;
          3'b111: d_alu = ALU_AND;
          3'b001: begin
            d_alu = ALU_SLL;
            d_b   = {27'b0, shamt};
            if (funct7 != F7_BASE) d_illegal = 1'b1;
          end
          3'b101: begin
            d_alu = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            d_b   = {27'b0, shamt};
            if (funct7 != F7_BASE && funct7 != F7_ALT) d_illegal = 1'b1;
          end
          default: d_illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        d_alu     = ALU_ADD;
        d_a       = bus.rs1_data;
        d_b       = imm_i;
        d_imm     = imm_i;
        d_writer  = 1'b1;
        d_memread = 1'b1;
        if (funct3 != 3'b010) d_illegal = 1'b1;
      end
      OP_STORE: begin
        d_alu      = ALU_ADD;
        d_a        = bus.rs1_data;
        d_b        = imm_s;
        d_imm      = imm_s;
        d_memwrite = 1'b1;
        if (funct3 != 3'b010) d_illegal = 1'b1;
      end
      OP_BRANCH: begin
        d_alu    = ALU_SUB;
        d_a      = bus.rs1_data;
        d_b      = bus.rs2_data;
        d_imm    = imm_b;
        d_branch = 1'b1;
        if (funct3 != 3'b000 && funct3 != 3'b001) d_illegal = 1'b1;
      end
      OP_LUI: begin
        d_alu    = ALU_ADD;
        d_b      = imm_u;
        d_imm    = imm_u;
        d_writer = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase

    // Illegal encodings issue as an inert entry carrying only the flag.
    if (d_illegal) begin
      d_a        = '0;
      d_b        = '0;
      d_imm      = '0;
      d_alu      = ALU_AND;
      d_writer   = 1'b0;
      d_memread  = 1'b0;
      d_memwrite = 1'b0;
      d_branch   = 1'b0;
    end
  end

  // Writes to x0 are discarded, so they never request a writeback.
  assign d_rd       = d_writer ? rd : 5'd0;
  assign d_regwrite = d_writer & (rd != 5'd0);

  logic        valid_q;
  logic [31:0] a_q, b_q, imm_q, pc_q, count_q;
  logic [3:0]  alu_q;
  logic [4:0]  rd_q;
  logic        regwrite_q, memread_q, memwrite_q, branch_q, illegal_q;
  logic        in_ready, fire;

  assign in_ready = ~valid_q | bus.ex_ready;
  assign fire     = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      alu_q      <= ALU_AND;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      illegal_q  <= 1'b0;
      count_q    <= '0;
    end else if (bus.flush) begin
      // Data fields hold; control bits drop so a dead entry never looks active.
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (fire) begin
      valid_q    <= 1'b1;
      a_q        <= d_a;
      b_q        <= d_b;
      imm_q      <= d_imm;
      pc_q       <= bus.in_pc;
      alu_q      <= d_alu;
      rd_q       <= d_rd;
      regwrite_q <= d_regwrite;
      memread_q  <= d_memread;
      memwrite_q <= d_memwrite;
      branch_q   <= d_branch;
      illegal_q  <= d_illegal;
      count_q    <= count_q + 32'd1;
    end else if (bus.ex_ready) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_A          = a_q;
  assign bus.ex_B          = b_q;
  assign bus.ex_ALUcontrol = alu_q;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_regwrite   = regwrite_q;
  assign bus.ex_memread    = memread_q;
  assign bus.ex_memwrite   = memwrite_q;
  assign bus.ex_branch     = branch_q;
  assign bus.ex_illegal    = illegal_q;
  assign bus.issue_count   = count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage - scoreboard bench for id_ex_stage: directed cases followed
// by randomized traffic checked against a mnemonic-level reference decoder.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] a, b, imm, pc;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  ctrl; // {regwrite, memread, memwrite, branch, illegal}
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_valid = 1'b0;
  logic [31:0] m_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Name the instruction the way an assembler listing would.
  function automatic string mnem(input logic [31:0] i);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    mnem = "bad";
    case (opc)
      7'h33: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: mnem = "add";  3'd1: mnem = "sll"; 3'd4: mnem = "xor";
            3'd5: mnem = "srl";  3'd6: mnem = "or";  3'd7: mnem = "and";
            default: mnem = "bad";
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'd0) mnem = "sub";
          else if (f3 == 3'd5) mnem = "sra";
        end
      end
      7'h13: begin
        case (f3)
          3'd0: mnem = "addi"; 3'd4: mnem = "xori"; 3'd6: mnem = "ori"; 3'd7: mnem = "andi";
          3'd1: if (f7 == 7'h00) mnem = "slli";
          3'd5: if (f7 == 7'h00) mnem = "srli"; else if (f7 == 7'h20) mnem = "srai";
          default: mnem = "bad";
        endcase
      end
      7'h03: if (f3 == 3'd2) mnem = "lw";
      7'h23: if (f3 == 3'd2) mnem = "sw";
      7'h63: if (f3 == 3'd0) mnem = "beq"; else if (f3 == 3'd1) mnem = "bne";
      7'h37: mnem = "lui";
      default: mnem = "bad";
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    string m;
    logic [31:0] iimm, simm, bimm, uimm;
    bit writer, mr, mw, br;
    iimm = {{20{i[31]}}, i[31:20]};
    simm = {{20{i[31]}}, i[31:25], i[11:7]};
    bimm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    uimm = {i[31:12], 12'h000};
    m = mnem(i);
    e = '0;
    e.pc = pc;
    writer = 0; mr = 0; mw = 0; br = 0;
    case (m)
      "add":  begin e.op = 4'd2; e.a = r1; e.b = r2; writer = 1; end
      "sub":  begin e.op = 4'd6; e.a = r1; e.b = r2; writer = 1; end
      "and":  begin e.op = 4'd0; e.a = r1; e.b = r2; writer = 1; end
      "or":   begin e.op = 4'd1; e.a = r1; e.b = r2; writer = 1; end
      "xor":  begin e.op = 4'd3; e.a = r1; e.b = r2; writer = 1; end
      "sll":  begin e.op = 4'd4; e.a = r1; e.b = r2 % 32; writer = 1; end
      "srl":  begin e.op = 4'd5; e.a = r1; e.b = r2 % 32; writer = 1; end
      "sra":  begin e.op = 4'd7; e.a = r1; e.b = r2 % 32; writer = 1; end
      "addi": begin e.op = 4'd2; e.a = r1; e.b = iimm; e.imm = iimm; writer = 1; end
      "andi": begin e.op = 4'd0; e.a = r1; e.b = iimm; e.imm = iimm; writer = 1; end
      "ori":  begin e.op = 4'd1; e.a = r1; e.b = iimm; e.imm = iimm; writer = 1; end
      "xori": begin e.op = 4'd3; e.a = r1; e.b = iimm; e.imm = iimm; writer = 1; end
      "slli": begin e.op = 4'd4; e.a = r1; e.b = 32'(i[24:20]); e.imm = iimm; writer = 1; end
      "srli": begin e.op = 4'd5; e.a = r1; e.b = 32'(i[24:20]); e.imm = iimm; writer = 1; end
      "srai": begin e.op = 4'd7; e.a = r1; e.b = 32'(i[24:20]); e.imm = iimm; writer = 1; end
      "lw":   begin e.op = 4'd2; e.a = r1; e.b = iimm; e.imm = iimm; writer = 1; mr = 1; end
      "sw":   begin e.op = 4'd2; e.a = r1; e.b = simm; e.imm = simm; mw = 1; end
      "beq", "bne": begin e.op = 4'd6; e.a = r1; e.b = r2; e.imm = bimm; br = 1; end
      "lui":  begin e.op = 4'd2; e.a = 0; e.b = uimm; e.imm = uimm; writer = 1; end
      default: e.ctrl = 5'b00001;
    endcase
    if (writer) e.rd = i[11:7];
    if (m != "bad") e.ctrl = {writer && (i[11:7] != 0), mr, mw, br, 1'b0};
    return e;
  endfunction

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.ex_valid && !bus.flush) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("ex_A", bus.ex_A, sbq[0].a);
        chk("ex_B", bus.ex_B, sbq[0].b);
        chk("ex_ALUcontrol", 32'(bus.ex_ALUcontrol), 32'(sbq[0].op));
        chk("ex_imm", bus.ex_imm, sbq[0].imm);
        chk("ex_pc", bus.ex_pc, sbq[0].pc);
        chk("ex_rd", 32'(bus.ex_rd), 32'(sbq[0].rd));
        chk("ex_ctrl", 32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
                            bus.ex_branch, bus.ex_illegal}), 32'(sbq[0].ctrl));
        if (bus.ex_ready) void'(sbq.pop_front());
      end
    end
  end

  // Driver: applies one cycle of stimulus and advances the transaction model.
  task automatic step(input bit r, input bit v, input bit fl, input bit er,
                      input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    bit fire;
    rst = r; bus.in_valid = v; bus.flush = fl; bus.ex_ready = er;
    bus.in_instr = ins; bus.in_pc = pc; bus.rs1_data = r1; bus.rs2_data = r2;
    @(negedge clk); #1;
    if (!r) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || er));
      chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
      chk("issue_count", bus.issue_count, m_count);
    end
    if (r) begin
      sbq.delete(); m_valid = 0; m_count = 0;
    end else if (fl) begin
      sbq.delete(); m_valid = 0;
    end else begin
      fire = v && (!m_valid || er);
      if (m_valid && er) m_valid = 0;
      if (fire) begin
        sbq.push_back(ref_decode(ins, pc, r1, r2));
        m_valid = 1;
        m_count = m_count + 1;
      end
    end
    @(posedge clk); #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k, t;
    r = $urandom;
    k = $urandom_range(0, 9);
    t = $urandom_range(0, 3);
    case (k)
      0, 1: begin
        r[6:0] = 7'h33;
        r[31:25] = (t < 2) ? 7'h00 : (t == 2) ? 7'h20 : r[31:25];
      end
      2, 3: begin
        r[6:0] = 7'h13;
        if (r[13:12] == 2'b01) r[31:25] = (t < 2) ? 7'h00 : (t == 2) ? 7'h20 : r[31:25];
      end
      4: begin r[6:0] = 7'h03; r[14:12] = 3'd2; end
      5: begin r[6:0] = 7'h23; r[14:12] = 3'd2; end
      6: begin r[6:0] = 7'h63; r[14:12] = 3'(t % 2); end
      7: r[6:0] = 7'h37;
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_ex_valid"}, 32'(bus.ex_valid), 0);
    chk({tag, "_ex_A"}, bus.ex_A, 0);
    chk({tag, "_ex_B"}, bus.ex_B, 0);
    chk({tag, "_alu"}, 32'(bus.ex_ALUcontrol), 0);
    chk({tag, "_imm"}, bus.ex_imm, 0);
    chk({tag, "_pc"}, bus.ex_pc, 0);
    chk({tag, "_rd"}, 32'(bus.ex_rd), 0);
    chk({tag, "_ctrl"}, 32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
                             bus.ex_branch, bus.ex_illegal}), 0);
    chk({tag, "_count"}, bus.issue_count, 0);
  endtask

  initial begin
    logic [31:0] saved_a, saved_cnt;
    bus.in_valid = 0; bus.flush = 0; bus.ex_ready = 0;
    bus.in_instr = 0; bus.in_pc = 0; bus.rs1_data = 0; bus.rs2_data = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk_zero("reset");
    chk("reset_in_ready", 32'(bus.in_ready), 1);

    // ADD x3,x1,x2
    step(0, 1, 0, 1, 32'h002081B3, 32'h100, 5, 7);
    chk("add_A", bus.ex_A, 5);
    chk("add_B", bus.ex_B, 7);
    chk("add_alu", 32'(bus.ex_ALUcontrol), 32'h2);
    chk("add_rd", 32'(bus.ex_rd), 3);
    chk("add_regwrite", 32'(bus.ex_regwrite), 1);
    chk("add_count", bus.issue_count, 1);

    // SUB then SRAI back to back
    step(0, 1, 0, 1, 32'h407302B3, 32'h104, 32'h80000000, 32'h1);
    chk("sub_alu", 32'(bus.ex_ALUcontrol), 32'h6);
    step(0, 1, 0, 1, 32'h40315093, 32'h108, 32'h80000000, 32'h1);
    chk("srai_alu", 32'(bus.ex_ALUcontrol), 32'h7);
    chk("srai_B", bus.ex_B, 32'h3);

    // ADDI x1,x0,-1 then SW x2,8(x1)
    step(0, 1, 0, 1, 32'hFFF00093, 32'h10C, 0, 0);
    chk("addi_B", bus.ex_B, 32'hFFFFFFFF);
    chk("addi_alu", 32'(bus.ex_ALUcontrol), 32'h2);
    step(0, 1, 0, 1, 32'h0020A423, 32'h110, 32'h40, 32'h99);
    chk("sw_B", bus.ex_B, 8);
    chk("sw_memwrite", 32'(bus.ex_memwrite), 1);
    chk("sw_regwrite", 32'(bus.ex_regwrite), 0);
    chk("sw_rd", 32'(bus.ex_rd), 0);

    // SLT is not supported
    step(0, 1, 0, 1, 32'h003120B3, 32'h114, 32'h12, 32'h34);
    chk("slt_illegal", 32'(bus.ex_illegal), 1);
    chk("slt_alu", 32'(bus.ex_ALUcontrol), 0);
    chk("slt_AB", bus.ex_A | bus.ex_B, 0);
    chk("slt_ctrl", 32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_branch}), 0);

    // Three-cycle stall with a pending instruction, then release
    step(0, 1, 0, 1, 32'h00500213, 32'h118, 11, 0);
    saved_a = bus.ex_A;
    saved_cnt = bus.issue_count;
    repeat (3) begin
      step(0, 1, 0, 0, 32'h002081B3, 32'h11C, 22, 1);
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_A_hold", bus.ex_A, saved_a);
      chk("stall_count_hold", bus.issue_count, saved_cnt);
    end
    step(0, 1, 0, 1, 32'h002081B3, 32'h11C, 22, 1);
    chk("release_A", bus.ex_A, 22);
    chk("release_count", bus.issue_count, saved_cnt + 1);

    // Flush kills held and incoming
    step(0, 1, 1, 0, 32'h00108093, 32'h120, 3, 3);
    chk("flush_valid", 32'(bus.ex_valid), 0);
    chk("flush_count", bus.issue_count, saved_cnt + 1);

    // Reset during a stall
    step(0, 1, 0, 1, 32'h0020A423, 32'h124, 7, 7);
    step(0, 1, 0, 0, 32'h002081B3, 32'h128, 7, 7);
    step(1, 1, 0, 0, 32'h002081B3, 32'h128, 7, 7);
    chk_zero("rst_stall");

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           rand_instr(), $urandom, $urandom,
           ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 63)));
    end
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
